// File: rtl/apa102_frame_tx_if.sv
// Bus bundle between the APA102 strand serializer and its upstream pattern generator.
// The master side is the pattern generator; the slave side is the serializer.
interface apa102_frame_tx_if #(
  parameter int IDXW = 4
);
  logic            start;
  logic [4:0]      globalbrightness;
  logic [IDXW-1:0] pix_idx;
  logic [23:0]     pix_rgb;
  logic            sck;
  logic            mosi;
  logic            busy;
  logic            done;

  modport master (
    output start, globalbrightness, pix_rgb,
    input  pix_idx, sck, mosi, busy, done
  );

  modport slave (
    input  start, globalbrightness, pix_rgb,
    output pix_idx, sck, mosi, busy, done
  );
endinterface

// File: rtl/apa102_frame_tx.sv
// APA102 strand serializer: one start frame, NUMLEDS LED frames and one end frame per
// accepted start, MSB first; pixel colours are fetched one LED ahead of the shifter.
module apa102_frame_tx #(
  parameter int NUMLEDS = 14,
  parameter int HALF    = 64,
  parameter int IDXW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  apa102_frame_tx_if.slave  bus
);

  localparam int PW = $clog2(2 * HALF);
  localparam logic [PW-1:0]   PH_RISE  = PW'(HALF - 1);
  localparam logic [PW-1:0]   PH_LAST  = PW'(2 * HALF - 1);
  localparam logic [IDXW-1:0] LED_LAST = IDXW'(NUMLEDS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_LED   = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

  logic [1:0]      state;
  logic [PW-1:0]   phase;
  logic [4:0]      bit_cnt;
  logic [IDXW-1:0] led_cnt;
  logic [IDXW-1:0] pix_idx;
  logic [31:0]     shreg;
  logic [4:0]      bright;
  logic            sck;
  logic            done;

  logic        bit_end;
  logic [31:0] led_word;

  assign bit_end  = (phase == PH_LAST);
  assign led_word = {3'b111, bright, bus.pix_rgb};

  // NOTE: state is updated with non-blocking assignments and cleared by the async
  // reset, so an abandoned transfer leaves no trace and never pulses done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      led_cnt <= '0;
      pix_idx <= '0;
      shreg   <= '0;
      bright  <= '0;
      sck     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.start) begin
          state   <= ST_START;
          bright  <= bus.globalbrightness;
          phase   <= '0;
          bit_cnt <= '0;
          led_cnt <= '0;
          shreg   <= '0;
          sck     <= 1'b0;
        end
      end else if (!bit_end) begin
        phase <= phase + 1'b1;
        if (phase == PH_RISE) sck <= 1'b1;
      end else begin
        phase   <= '0;
        sck     <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {shreg[30:0], 1'b0};

        // Present the next LED index for a full bit before its word is loaded.
        if (bit_cnt == 5'd30) begin
          if (state == ST_START)
            pix_idx <= '0;
          else if (state == ST_LED && led_cnt != LED_LAST)
            pix_idx <= led_cnt + 1'b1;
        end

        if (bit_cnt == 5'd31) begin
          case (state)
            ST_START: begin
              state   <= ST_LED;
              led_cnt <= '0;
              shreg   <= led_word;
            end
            ST_LED: begin
              if (led_cnt == LED_LAST) begin
                state <= ST_END;
                shreg <= '1;
              end else begin
                led_cnt <= led_cnt + 1'b1;
                shreg   <= led_word;
              end
            end
            default: begin
              state <= ST_IDLE;
              shreg <= '0;
              done  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign bus.pix_idx = pix_idx;
  assign bus.sck     = sck;
  assign bus.mosi    = shreg[31];
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = done;

endmodule

// File: tb/tb_apa102_frame_tx.sv
// Scoreboard bench for apa102_frame_tx: stimulus pushes expected strand words, a monitor
// rebuilds words from sck rises and checks them along with bit timing.
module tb_apa102_frame_tx;

  localparam int NUMLEDS = 2;
  localparam int HALF    = 2;
  localparam int IDXW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  apa102_frame_tx_if #(.IDXW(IDXW)) bus ();

  apa102_frame_tx #(
    .NUMLEDS(NUMLEDS),
    .HALF   (HALF),
    .IDXW   (IDXW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Upstream colour source: combinational lookup on the requested index.
  logic [23:0] tab [16];
  assign bus.pix_rgb = tab[bus.pix_idx];

  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling clk edge, away from DUT updates.
  int          sck_rises   = 0;
  int          busy_cycles = 0;
  int          done_cnt    = 0;
  int          timing_err  = 0;
  int          bit_n       = 0;
  int          run         = 0;
  logic [31:0] word        = '0;
  logic        p_sck = 1'b0, p_mosi = 1'b0, p_busy = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      bit_n  = 0;
      run    = 0;
      p_sck  = 1'b0;
      p_mosi = 1'b0;
      p_busy = 1'b0;
    end else begin
      if (bus.sck && !p_sck) begin
        sck_rises++;
        word = {word[30:0], bus.mosi};
        bit_n++;
        if (bit_n == 32) begin
          bit_n = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", word);
          end else begin
            check("frame_word", word, exp_q.pop_front());
          end
        end
      end
      if (bus.mosi !== p_mosi && !(p_sck && !bus.sck) && !(bus.busy && !p_busy))
        timing_err++;
      if (bus.busy) begin
        if (!p_busy) run = 1;
        else if (bus.sck == p_sck) run++;
        else begin
          if (run != HALF) timing_err++;
          run = 1;
        end
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) done_cnt++;
      p_sck  = bus.sck;
      p_mosi = bus.mosi;
      p_busy = bus.busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_rises(input int n, input string name);
    int k = 0;
    while (sck_rises < n && k < 4000) begin
      tick();
      k++;
    end
    check(name, 32'(sck_rises >= n), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!bus.done && k < 2000) begin
      tick();
      k++;
    end
    check(name, 32'(bus.done), 32'd1);
  endtask

  int r0, b0, d0, t0, bad;

  initial begin
    bus.start            = 1'b0;
    bus.globalbrightness = '0;
    for (int i = 0; i < 16; i++) tab[i] = '0;

    // Reset and idle
    reset = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {24'd0, bus.sck, bus.mosi, bus.busy, bus.done, bus.pix_idx}, 32'd0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sck || bus.mosi || bus.busy || bus.done) bad++;
    end
    check("idle_outputs", bad, 0);

    // Single frame with start acceptance and first-bit timing
    bus.globalbrightness = 5'b10101;
    tab[0] = 24'h0000FF;
    tab[1] = 24'hFF0000;
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hF50000FF);
    exp_q.push_back(32'hF5FF0000);
    exp_q.push_back(32'hFFFFFFFF);
    r0 = sck_rises; b0 = busy_cycles; d0 = done_cnt; t0 = timing_err;
    pulse_start();
    check("accept_busy_sck_mosi", {29'd0, bus.busy, bus.sck, bus.mosi}, 32'b100);
    tick();
    check("sck_low_2nd", 32'(bus.sck), 32'd0);
    tick();
    check("sck_first_rise", 32'(bus.sck), 32'd1);
    wait_done("single_done_seen");
    tick();
    check("done_width", 32'(bus.done), 32'd0);
    check("single_rises", sck_rises - r0, 128);
    check("single_busy_cycles", busy_cycles - b0, 512);
    check("single_done_count", done_cnt - d0, 1);
    check("single_timing", timing_err - t0, 0);
    check("pix_idx_hold", 32'(bus.pix_idx), 32'(NUMLEDS - 1));
    check("single_queue_empty", exp_q.size(), 0);

    // Start while busy is ignored; start on the done cycle is accepted
    bus.globalbrightness = 5'b00011;
    tab[0] = 24'h123456;
    tab[1] = 24'hABCDEF;
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hE3123456);
    exp_q.push_back(32'hE3ABCDEF);
    exp_q.push_back(32'hFFFFFFFF);
    r0 = sck_rises; d0 = done_cnt; t0 = timing_err;
    pulse_start();
    wait_rises(r0 + 40, "busy_wait_led");
    pulse_start();
    wait_done("busy_done_seen");
    bus.globalbrightness = 5'b11111;
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hFF123456);
    exp_q.push_back(32'hFFABCDEF);
    exp_q.push_back(32'hFFFFFFFF);
    pulse_start();
    check("restart_on_done", 32'(bus.busy), 32'd1);
    check("busy_one_done", done_cnt - d0, 1);
    check("busy_one_transfer", sck_rises - r0, 128);
    wait_done("restart_done_seen");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy) bad++;
    end
    check("no_queued_start", bad, 0);
    check("restart_rises", sck_rises - r0, 256);
    check("restart_done_count", done_cnt - d0, 2);
    check("restart_timing", timing_err - t0, 0);

    // Reset during LED frame 0 bit 10
    bus.globalbrightness = 5'b00001;
    tab[0] = 24'hA5A5A5;
    tab[1] = 24'h5A5A5A;
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hE1A5A5A5);
    exp_q.push_back(32'hE15A5A5A);
    exp_q.push_back(32'hFFFFFFFF);
    r0 = sck_rises; d0 = done_cnt;
    pulse_start();
    wait_rises(r0 + 43, "reset_wait_bit10");
    check("pre_reset_active", {29'd0, bus.sck, bus.mosi, bus.busy}, 32'b111);
    reset = 1'b0;
    #1;
    check("async_reset", {28'd0, bus.sck, bus.mosi, bus.busy, bus.done}, 32'd0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("reset_no_done", done_cnt - d0, 0);
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hE1A5A5A5);
    exp_q.push_back(32'hE15A5A5A);
    exp_q.push_back(32'hFFFFFFFF);
    r0 = sck_rises; t0 = timing_err;
    pulse_start();
    wait_done("post_reset_done_seen");
    check("post_reset_rises", sck_rises - r0, 128);
    check("post_reset_timing", timing_err - t0, 0);

    // Late changes to pixel data and brightness
    bus.globalbrightness = 5'b01111;
    tab[0] = 24'h00FF00;
    tab[1] = 24'h0000AA;
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'hEF00FF00);
    exp_q.push_back(32'hEF112233);
    exp_q.push_back(32'hFFFFFFFF);
    r0 = sck_rises;
    pulse_start();
    wait_rises(r0 + 40, "late_wait_led0");
    tab[0] = 24'hFFFFFF;
    tab[1] = 24'h112233;
    bus.globalbrightness = 5'b00000;
    wait_done("late_done_seen");
    tick();
    check("late_rises", sck_rises - r0, 128);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apa102_frame_tx.md
Name: apa102_frame_tx

Overview:
- Downstream serializer for one APA102 LED strand. Sends start frame, NUMLEDS LED frames and end frame, MSB first, on its own sck/mosi pair.
- Replaces the free-running shift-and-reload scheme with a start/busy/done handshake, so every transmitted frame is complete and consistent.
- Pixel colours are fetched one LED at a time through an index/data port from an upstream pattern generator (rain or lantern colour logic).

Parameters:
- NUMLEDS, 14, number of LED frames per transfer (≥1)
- HALF, 64, sck half-period in clk cycles (≥1); default gives 128-clk bit period
- IDXW, 4, width of pix_idx (must hold NUMLEDS-1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request one frame transfer; sampled when idle
- globalbrightness  in  5  brightness field, latched at accepted start
- pix_idx  out  IDXW  index of LED whose colour is requested
- pix_rgb  in  24  {blue,green,red} for pix_idx, combinational from upstream
- sck  out  1  strand clock
- mosi  out  1  strand data
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse at end of transfer

Behaviour:
- Reset (reset=0, async): state IDLE, sck=0, mosi=0, busy=0, done=0, pix_idx=0. Any in-flight transfer is abandoned; there is no partial completion and no done pulse.
- States: IDLE -> START (32 bits of 0) -> LED (NUMLEDS×32 bits) -> END (32 bits of 1) -> IDLE.
- Start acceptance:
  - start=1 in IDLE at edge t: at t+1, busy=1, state START, mosi = bit 31 of start frame (0), sck=0. globalbrightness is latched at t.
  - start while busy is ignored; it is not queued.
- Bit timing:
  - Each bit is 2×HALF clk cycles: sck=0 for the first HALF cycles, 1 for the next HALF.
  - mosi changes only at the start of a bit, while sck=0. The strand samples on the sck rising edge.
  - First sck rise at t+1+HALF.
- LED word: {3'b111, latched brightness, blue, green, red}, bit 31 first.
- Pixel fetch:
  - pix_idx is set to the next LED index at the start of the last bit of the preceding word. The start frame's bit 0 sets it to 0; LED k's bit 0 sets it to k+1.
  - pix_rgb is sampled on the final clk of that bit, which is the edge that begins the next word. Upstream gets ≥2×HALF cycles of stable index.
  - After the last LED, pix_idx holds NUMLEDS-1.
- Counters: bit counter 0..31 within a word, wrapping into the next word or state. LED counter 0..NUMLEDS-1. Phase counter 0..2×HALF-1.
- End of transfer:
  - After END bit 0's high phase, at the next edge: state IDLE, sck=0, mosi=0, busy=0, done=1 for exactly one cycle.
  - A start asserted in that same cycle (done=1, state IDLE) is accepted normally. Back-to-back transfers therefore have a 1-cycle idle gap.
- Total transfer: 32×(NUMLEDS+2)×2×HALF clk cycles, from busy rising to done.
- globalbrightness and pix_rgb changes outside their sample points have no effect.
- sck idles low; mosi idles 0.

Test Plan:
- Reset/idle: NUMLEDS=2, HALF=2; hold reset=0, then release, no start -> sck=0, mosi=0, busy=0, done=0 indefinitely.
- Single frame:
  - Stimulus: NUMLEDS=2, HALF=2; start pulse; brightness=5'b10101; pix_rgb = idx0 24'h0000FF, idx1 24'hFF0000.
  - Required: bits captured on sck rises are 32'h00000000, 32'hF50000FF, 32'hF5FF0000, 32'hFFFFFFFF.
  - Required: 128 sck rises, busy high for 512 cycles, single done pulse.
- Timing: HALF=2 -> sck pattern 0,0,1,1 per bit. mosi is stable across every rise and changes only on the cycle sck falls or at transfer start.
- Start while busy: second start pulse mid-LED state -> ignored. Exactly one transfer and one done; a start on the done cycle begins a new transfer at the next edge.
- Reset mid-operation: assert reset during LED frame 0 bit 10 -> sck, mosi and busy go 0 immediately (async). No done pulse. A new start sends a full correct frame.
- Late data change: change pix_rgb and brightness while LED 0 is shifting -> the shifted LED 0 word is unchanged. LED 1 reflects pix_rgb sampled at its load edge; brightness stays as latched at start.
